// File: rtl/traffic_light_controller_if.sv
// Control/status bundle between the traffic light controller and its host
// (dot matrix display driver, pedestrian button, maintenance switch).
interface traffic_light_controller_if;
  logic       Enable;
  logic       Ped_Req;
  logic       Maint;
  logic [1:0] Current_State;
  logic [3:0] Sec_Left;
  logic       State_Change;
  logic       Ped_Ack;

  modport master (
    output Enable, Ped_Req, Maint,
    input  Current_State, Sec_Left, State_Change, Ped_Ack
  );

  modport slave (
    input  Enable, Ped_Req, Maint,
    output Current_State, Sec_Left, State_Change, Ped_Ack
  );
endinterface

// File: rtl/traffic_light_controller.sv
// RED -> GREEN -> YELLOW light sequencer with one-second prescaler, pedestrian
// shortening of GREEN and a blinking-yellow maintenance mode.
module traffic_light_controller #(
  parameter int unsigned TICKS_PER_SEC = 10000,
  parameter int unsigned RED_SEC       = 5,
  parameter int unsigned GREEN_SEC     = 5,
  parameter int unsigned YELLOW_SEC    = 2,
  parameter int unsigned PED_SEC       = 1
) (
  input  logic                              Clock_Div_10000Hz,
  input  logic                              Reset,
  traffic_light_controller_if.slave         bus
);

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10,
    NONE   = 2'b11
  } state_e;

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  state_e        state;
  logic [3:0]    sec_left;
  logic [PW-1:0] presc;
  logic          state_change;
  logic          ped_ack;
  logic          maint_q;

  logic          sec_tick;
  logic [PW-1:0] presc_next;
  logic          ped_hit;
  state_e        seq_next;

  function automatic logic [3:0] duration(state_e s);
    case (s)
      RED:     duration = 4'(RED_SEC);
      GREEN:   duration = 4'(GREEN_SEC);
      YELLOW:  duration = 4'(YELLOW_SEC);
      default: duration = '0;
    endcase
  endfunction

  always_comb begin
    sec_tick   = (presc == PRESC_MAX);
    presc_next = sec_tick ? '0 : presc + PW'(1);
    ped_hit    = bus.Ped_Req && (state == GREEN) && (sec_left > 4'(PED_SEC));
    case (state)
      RED:     seq_next = GREEN;
      GREEN:   seq_next = YELLOW;
      default: seq_next = RED;
    endcase
  end

  // maint_q distinguishes the entry/exit edges of maintenance from steady blinking.
  always_ff @(posedge Clock_Div_10000Hz or negedge Reset) begin
    if (!Reset) begin
      state        <= RED;
      sec_left     <= 4'(RED_SEC);
      presc        <= '0;
      state_change <= 1'b0;
      ped_ack      <= 1'b0;
      maint_q      <= 1'b0;
    end else begin
      state_change <= 1'b0;
      ped_ack      <= 1'b0;
      maint_q      <= bus.Maint;
      if (bus.Maint && !maint_q) begin
        state        <= YELLOW;
        sec_left     <= '0;
        presc        <= '0;
        state_change <= (state != YELLOW);
      end else if (bus.Maint) begin
        presc <= presc_next;
        if (sec_tick) begin
          state        <= (state == YELLOW) ? NONE : YELLOW;
          state_change <= 1'b1;
        end
      end else if (maint_q) begin
        state        <= RED;
        sec_left     <= 4'(RED_SEC);
        presc        <= '0;
        state_change <= (state != RED);
      end else if (bus.Enable) begin
        presc <= presc_next;
        // Truncation takes precedence over a coincident one-second decrement.
        if (ped_hit) begin
          sec_left <= 4'(PED_SEC);
          ped_ack  <= 1'b1;
        end else if (sec_tick) begin
          if (sec_left > 4'd1) begin
            sec_left <= sec_left - 4'd1;
          end else begin
            state        <= seq_next;
            sec_left     <= duration(seq_next);
            state_change <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.Current_State = state;
  assign bus.Sec_Left      = sec_left;
  assign bus.State_Change  = state_change;
  assign bus.Ped_Ack       = ped_ack;

endmodule

// File: doc/traffic_light_controller.md
TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 Parameter TICKS_PER_SEC, default 10000: Clock cycles per one-second tick.
REQ-002 Parameter RED_SEC, default 5: RED duration in seconds, legal range 1..15.
REQ-003 Parameter GREEN_SEC, default 5: GREEN duration in seconds, legal range 2..15.
REQ-004 Parameter YELLOW_SEC, default 2: YELLOW duration in seconds, legal range 1..15.
REQ-005 Parameter PED_SEC, default 1: GREEN remaining time after a pedestrian request, legal range 1..GREEN_SEC-1.
REQ-006 Clock  input  1  single clock (10 kHz display clock domain), all state updates on its rising edge.
REQ-007 Reset  input  1  asynchronous, active-low reset.
REQ-008 Enable  input  1  1 = run countdown, 0 = freeze timing.
REQ-009 Ped_Req  input  1  pedestrian request, level-sampled every cycle.
REQ-010 Maint  input  1  maintenance mode, blinking yellow.
REQ-011 Current_State  output  2  RED=2'b00, YELLOW=2'b01, GREEN=2'b10, NONE=2'b11; drives the dot matrix display state input.
REQ-012 Sec_Left  output  4  seconds remaining in the current state; 0 in maintenance.
REQ-013 State_Change  output  1  one-cycle pulse in the cycle Current_State takes a new value.
REQ-014 Ped_Ack  output  1  one-cycle pulse when a pedestrian request shortens GREEN.

Function
REQ-015 The prescaler SHALL count 0..TICKS_PER_SEC-1, advance only when Enable=1 or Maint=1, and wrap to 0; sec_tick is asserted in the cycle the count equals TICKS_PER_SEC-1.
REQ-016 The normal sequence SHALL be RED -> GREEN -> YELLOW -> RED, all outputs registered.
REQ-017 On sec_tick in normal mode: if Sec_Left>1, Sec_Left decrements; if Sec_Left==1, Current_State advances and Sec_Left loads the next state's duration in the same edge; each state lasts exactly duration*TICKS_PER_SEC cycles.
REQ-018 Ped_Req=1 with Current_State=GREEN, Enable=1, Maint=0 and Sec_Left>PED_SEC SHALL set Sec_Left=PED_SEC on the next edge and pulse Ped_Ack; the prescaler is not cleared.
REQ-019 If the REQ-018 condition and sec_tick coincide, truncation wins: Sec_Left=PED_SEC, no decrement that cycle.
REQ-020 Ped_Req SHALL be ignored outside GREEN, when Sec_Left<=PED_SEC, when Enable=0, or in maintenance; a held Ped_Req produces exactly one Ped_Ack per GREEN phase.
REQ-021 Enable=0 SHALL freeze prescaler, Sec_Left and Current_State.
REQ-022 Maint=1 has priority over Enable and Ped_Req: the next edge sets Current_State=YELLOW, Sec_Left=0, prescaler=0; thereafter each sec_tick toggles YELLOW<->NONE.
REQ-023 Maint falling SHALL, on the next edge, set Current_State=RED, Sec_Left=RED_SEC, prescaler=0.
REQ-024 State_Change SHALL pulse on every Current_State change, including maintenance entry, toggle and exit; it SHALL NOT pulse if entry or exit leaves the value unchanged.

Reset
REQ-025 Reset=0 SHALL immediately force Current_State=RED, Sec_Left=RED_SEC, prescaler=0, State_Change=0, Ped_Ack=0, Ped pending cleared, regardless of Clock or mid-phase activity.
REQ-026 After Reset rises, the first prescaler increment occurs on the first Clock edge with Enable=1 or Maint=1.

Verification (TICKS_PER_SEC=4, RED_SEC=3, GREEN_SEC=4, YELLOW_SEC=2, PED_SEC=1)
REQ-027 Release reset, Enable=1 -> RED/Sec_Left=3 for 12 cycles, then GREEN/Sec_Left=4 with one State_Change pulse.
REQ-028 Free run 36 cycles -> RED(12), GREEN(16), YELLOW(8), back to RED/Sec_Left=3; exactly 3 State_Change pulses.
REQ-029 Ped_Req held from first GREEN cycle -> next edge Sec_Left=1 with one Ped_Ack; YELLOW within 4 cycles; no further Ped_Ack. Ped_Req during RED -> no effect.
REQ-030 Enable=0 for 20 cycles mid-GREEN with Sec_Left=2 -> outputs unchanged; on resume, the remaining phase length equals its pre-freeze remainder.
REQ-031 Maint=1 mid-GREEN -> next edge YELLOW, Sec_Left=0; toggles to NONE every 4 cycles; Maint=0 -> next edge RED, Sec_Left=3.
REQ-032 Reset=0 asserted between edges during YELLOW -> RED/Sec_Left=3 without waiting for Clock.
